// File: rtl/instr_fetch_unit_if.sv
// Bundle between instr_fetch_unit and its loader/core neighbours.
// The slave modport is the fetch unit. The master modport is the boot loader plus core_main.
interface instr_fetch_unit_if;
  logic        enable;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_done;
  logic        load_err;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        fetch_fault;
  logic [31:0] fault_addr;
  logic [31:0] instr_count;

  modport master (
    output enable, load_valid, load_addr, load_data, load_done, redirect_valid, redirect_target,
    input  load_ready, load_err, instruction, pc, pc_plus4, instr_valid, fetch_fault, fault_addr,
           instr_count
  );

  modport slave (
    input  enable, load_valid, load_addr, load_data, load_done, redirect_valid, redirect_target,
    output load_ready, load_err, instruction, pc, pc_plus4, instr_valid, fetch_fault, fault_addr,
           instr_count
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: boot-loaded instruction memory, program counter and sticky fetch fault.
// The instruction read is combinational, so the core executes the word in the same cycle.
module instr_fetch_unit #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_unit_if.slave bus
);
  localparam int unsigned AW       = $clog2(IMEM_DEPTH);
  localparam logic [32:0] MemBytes = 33'(IMEM_DEPTH) << 2;

  typedef enum logic [1:0] {StBoot, StRun, StFault} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [31:0] count_q, count_d;
  logic        fault_q, fault_d;
  logic        load_err_q, load_err_d;
  logic [31:0] mem [IMEM_DEPTH];

  logic [32:0] seq_next, next_addr;
  logic        load_legal, next_legal, mem_we;

  // 33-bit compare so that pc+4 wrapping past 2^32 is seen as out of range.
  function automatic logic addr_legal(logic [32:0] a);
    return (a[1:0] == 2'b00) && (a < MemBytes);
  endfunction

  always_comb begin
    seq_next     = {1'b0, pc_q} + 33'd4;
    next_addr    = bus.redirect_valid ? {1'b0, bus.redirect_target} : seq_next;
    next_legal   = addr_legal(next_addr);
    load_legal   = addr_legal({1'b0, bus.load_addr});
    mem_we       = (state_q == StBoot) && bus.load_valid && load_legal;
    state_d      = state_q;
    pc_d         = pc_q;
    fault_addr_d = fault_addr_q;
    count_d      = count_q;
    fault_d      = fault_q;
    load_err_d   = 1'b0;
    unique case (state_q)
      StBoot: begin
        load_err_d = bus.load_valid && !load_legal;
        if (bus.load_done) begin
          state_d = StRun;
          pc_d    = RESET_PC;
        end
      end
      StRun: begin
        if (bus.enable) begin
          // The current instruction retires even when its successor faults.
          count_d = count_q + 32'd1;
          if (next_legal) begin
            pc_d = next_addr[31:0];
          end else begin
            fault_addr_d = next_addr[31:0];
            fault_d      = 1'b1;
            state_d      = StFault;
          end
        end
      end
      StFault: ;
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StBoot;
      pc_q         <= RESET_PC;
      fault_addr_q <= 32'h0;
      count_q      <= 32'h0;
      fault_q      <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_addr_q <= fault_addr_d;
      count_q      <= count_d;
      fault_q      <= fault_d;
      load_err_q   <= load_err_d;
    end
  end

  // Memory is deliberately outside reset so a rebooted core keeps its image.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[bus.load_addr[AW+1:2]] <= bus.load_data;
    end
  end

  assign bus.load_ready  = (state_q == StBoot);
  assign bus.load_err    = load_err_q;
  assign bus.instruction = (state_q == StRun) ? mem[pc_q[AW+1:2]] : NOP_INSTR;
  assign bus.instr_valid = (state_q == StRun) && bus.enable;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_q + 32'd4;
  assign bus.fetch_fault = fault_q;
  assign bus.fault_addr  = fault_addr_q;
  assign bus.instr_count = count_q;
endmodule
